// File: rtl/icache_line_fill_pkg.sv
// Shared types and constants for the instruction cache refill block.
// Line geometry, FSM encoding and the tag-width helper live here.
package icache_line_fill_pkg;

    localparam int LINE_BITS   = 512;
    localparam int BEAT_BITS   = 128;
    localparam int OFFSET_BITS = 6;
    localparam int WORD_BITS   = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_INSTALL,
        S_REPLAY
    } state_t;

    // Tag is whatever remains above the line offset and index fields.
    function automatic int tag_bits(input int addr_w, input int index_bits);
        return addr_w - OFFSET_BITS - index_bits;
    endfunction

endpackage

// File: rtl/icache_line_fill_if.sv
// Fetch-side and DDR-read-side signal bundle of the instruction cache.
// slave is the cache view; master is the fetch/memory view.
interface icache_line_fill_if
    import icache_line_fill_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]    pc;
    logic                 fetch_req;
    logic                 flush;
    logic [WORD_BITS-1:0] inst;
    logic                 inst_valid;
    logic                 stall;
    logic                 ishit;
    logic                 mem_req;
    logic [31:0]          mem_addr;
    logic                 mem_ready;
    logic [BEAT_BITS-1:0] mem_data;

    modport slave (
        input  pc, fetch_req, flush, mem_ready, mem_data,
        output inst, inst_valid, stall, ishit, mem_req, mem_addr
    );

    modport master (
        output pc, fetch_req, flush, mem_ready, mem_data,
        input  inst, inst_valid, stall, ishit, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_tag_data_ram.sv
// Valid/tag/line storage: registered read, whole-line synchronous write.
// Only the valid bits are reset; tag and data are qualified by them.
module icache_tag_data_ram
    import icache_line_fill_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_W      = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en_i,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [LINE_BITS-1:0]  rd_line_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [LINE_BITS-1:0]  wr_line_i,
    input  logic                  inv_all_i
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]     valid_q;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [LINE_BITS-1:0] line_q [LINES];
    logic                 rd_valid_q;
    logic [TAG_W-1:0]     rd_tag_q;
    logic [LINE_BITS-1:0] rd_line_q;

    // Valid bits: bulk invalidate beats a fill (they never coincide).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (inv_all_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and line arrays, written as a whole line.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            line_q[wr_idx_i] <= wr_line_i;
        end
    end

    // One-cycle registered lookup port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_tag_q   <= '0;
            rd_line_q  <= '0;
        end else if (rd_en_i) begin
            rd_valid_q <= valid_q[rd_idx_i];
            rd_tag_q   <= tag_q[rd_idx_i];
            rd_line_q  <= line_q[rd_idx_i];
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_tag_o   = rd_tag_q;
    assign rd_line_o  = rd_line_q;

endmodule

// File: rtl/icache_line_fill.sv
// Direct-mapped instruction cache with a four-beat line refill FSM.
// Lookup result is resolved in the cycle after the fetch is accepted.
module icache_line_fill
    import icache_line_fill_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int ADDR_W     = 32,
    parameter int BEATS      = 4
) (
    input  logic               clk,
    input  logic               reset,
    icache_line_fill_if.slave  bus
);
    localparam int TAG_W = tag_bits(ADDR_W, INDEX_BITS);
    localparam int TAG_LO = OFFSET_BITS + INDEX_BITS;
    localparam int CNT_W = $clog2(BEATS);

    state_t               state_q, state_d;
    logic [ADDR_W-1:2]    pc_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic                 fp_q, fp_d;
    logic                 lookup_q, force_q, ishit_q;
    logic [LINE_BITS-1:0] fill_q;

    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_line;

    logic                 accept, hit, inv_all, stall;
    logic                 inst_valid, mem_req;
    logic [WORD_BITS-1:0] inst;
    logic [31:0]          base;
    logic [3:0]           word;

    assign word = pc_q[5:2];
    assign base = 32'({pc_q[ADDR_W-1:OFFSET_BITS], 2'b00});
    assign hit  = lookup_q && !force_q && rd_valid &&
                  (rd_tag == pc_q[ADDR_W-1:TAG_LO]);

    assign accept = bus.fetch_req && !stall &&
                    (state_q == S_IDLE || state_q == S_REPLAY);

    // A pending flush lands as the FSM leaves REPLAY for IDLE.
    assign inv_all = (bus.flush && (state_q == S_IDLE ||
                                    state_q == S_REPLAY)) ||
                     (state_q == S_REPLAY && fp_q);

    icache_tag_data_ram #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_ram (
        .clk        (clk),
        .reset      (reset),
        .rd_en_i    (accept),
        .rd_idx_i   (bus.pc[TAG_LO-1:OFFSET_BITS]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .wr_en_i    (state_q == S_INSTALL),
        .wr_idx_i   (pc_q[TAG_LO-1:OFFSET_BITS]),
        .wr_tag_i   (pc_q[ADDR_W-1:TAG_LO]),
        .wr_line_i  (fill_q),
        .inv_all_i  (inv_all)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state, refill control and fetch-side outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        fp_d       = fp_q;
        stall      = 1'b0;
        mem_req    = 1'b0;
        inst_valid = 1'b0;
        inst       = '0;
        unique case (state_q)
            S_IDLE: begin
                if (lookup_q) begin
                    if (hit) begin
                        inst_valid = 1'b1;
                        inst       = rd_line[{word, 5'b0} +: WORD_BITS];
                    end else begin
                        stall      = 1'b1;
                        cnt_d      = '0;
                        mem_addr_d = base;
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                stall = 1'b1;
                if (bus.mem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = S_INSTALL;
                    end else begin
                        mem_addr_d = base + 32'(cnt_q) + 32'd1;
                        state_d    = S_REQ;
                    end
                end
            end
            S_INSTALL: begin
                stall   = 1'b1;
                state_d = S_REPLAY;
            end
            S_REPLAY: begin
                inst_valid = 1'b1;
                inst       = fill_q[{word, 5'b0} +: WORD_BITS];
                fp_d       = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush && stall && state_q != S_IDLE) fp_d = 1'b1;
    end

    // Request latch, beat assembly and refill bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= '0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            fp_q       <= 1'b0;
            lookup_q   <= 1'b0;
            force_q    <= 1'b0;
            ishit_q    <= 1'b0;
            fill_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            fp_q       <= fp_d;
            lookup_q   <= accept;
            force_q    <= accept && (bus.flush ||
                          (state_q == S_REPLAY && fp_q));
            if (accept) pc_q <= bus.pc[ADDR_W-1:2];
            if (lookup_q) ishit_q <= hit;
            if (state_q == S_WAIT && bus.mem_ready)
                fill_q[{cnt_q, 7'b0} +: BEAT_BITS] <= bus.mem_data;
        end
    end

    assign bus.inst       = inst;
    assign bus.inst_valid = inst_valid;
    assign bus.stall      = stall;
    assign bus.ishit      = lookup_q ? hit : ishit_q;
    assign bus.mem_req    = mem_req;
    assign bus.mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache_line_fill.sv
// Scoreboard bench for icache_line_fill with a 5-cycle-latency memory.
// Inputs change and outputs are sampled on the falling edge.
module tb_icache_line_fill;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    icache_line_fill_if bus ();

    icache_line_fill dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic        hit;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] addr_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          pend = 0;
    int          ready_cnt = 0;
    logic [31:0] last_addr = '0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [31:0] line;
        line = pc >> 6;
        return 32'h1000_0000 + 32'(pc[5:4]) * 4 + 32'(pc[3:2]) +
               ((line - 1) << 16);
    endfunction

    function automatic logic [127:0] beat_at(input logic [31:0] a);
        logic [127:0] d;
        for (int j = 0; j < 4; j++)
            d[32*j +: 32] = word_at({a[27:0], 4'b0} + 32'(4 * j));
        return d;
    endfunction

    task automatic step();
        exp_t e;
        @(negedge clk);
        if (bus.mem_req) begin
            if (addr_q.size() == 0) check("mem_req_unexp", 64'(bus.mem_req), 0);
            else check("mem_addr", 64'(bus.mem_addr), 64'(addr_q.pop_front()));
        end
        if (bus.inst_valid) begin
            if (sb.size() == 0) begin
                check("inst_valid_unexp", 64'(bus.inst_valid), 0);
            end else begin
                e = sb.pop_front();
                check("inst", 64'(bus.inst), 64'(e.inst));
                check("ishit", 64'(bus.ishit), 64'(e.hit));
            end
        end
        bus.mem_ready = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                bus.mem_ready = 1'b1;
                bus.mem_data  = beat_at(last_addr);
                ready_cnt++;
            end
        end
        if (bus.mem_req) begin
            pend      = 5;
            last_addr = bus.mem_addr;
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input logic hit,
                         input int flush_at);
        int   cyc;
        exp_t e;
        cyc = 0;
        e.inst = word_at(pc);
        e.hit  = hit;
        sb.push_back(e);
        if (!hit)
            for (int k = 0; k < 4; k++)
                addr_q.push_back({4'b0, pc[31:6], 2'b00} + 32'(k));
        bus.pc        = pc;
        bus.fetch_req = 1'b1;
        bus.flush     = (flush_at == 0);
        while (sb.size() != 0 && cyc < 100) begin
            step();
            cyc++;
            bus.fetch_req = 1'b0;
            bus.flush     = (cyc == flush_at);
        end
        bus.flush = 1'b0;
        check("resp_pending", 64'(sb.size()), 0);
        check("beats_pending", 64'(addr_q.size()), 0);
        if (hit) check("hit_latency", 64'(cyc), 1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, 64'(bus.stall), 0);
        check({tag, "_mem_req"}, 64'(bus.mem_req), 0);
        check({tag, "_inst_valid"}, 64'(bus.inst_valid), 0);
    endtask

    initial begin
        int cyc;
        reset         = 1'b1;
        bus.pc        = '0;
        bus.fetch_req = 1'b0;
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_inst", 64'(bus.inst), 0);
        check("rst_ishit", 64'(bus.ishit), 0);
        check("rst_mem_addr", 64'(bus.mem_addr), 0);
        check_quiet("rst");
        reset = 1'b0;
        step();

        fetch(32'h44, 1'b0, -1);
        fetch(32'h78, 1'b1, -1);
        fetch(32'h240, 1'b0, -1);
        fetch(32'h44, 1'b0, -1);
        fetch(32'h44, 1'b1, -1);
        fetch(32'h80, 1'b0, 4);
        fetch(32'h80, 1'b0, -1);
        fetch(32'h44, 1'b0, -1);
        fetch(32'h80, 1'b1, -1);
        fetch(32'h44, 1'b0, 0);
        fetch(32'h44, 1'b1, -1);

        bus.mem_ready = 1'b1;
        bus.mem_data  = {4{32'hDEAD_BEEF}};
        step();
        step();
        check_quiet("spurious");
        check("spurious_ishit", 64'(bus.ishit), 1);
        fetch(32'h48, 1'b1, -1);

        for (int k = 0; k < 4; k++)
            addr_q.push_back(32'hC + 32'(k));
        ready_cnt     = 0;
        bus.pc        = 32'hC0;
        bus.fetch_req = 1'b1;
        step();
        bus.fetch_req = 1'b0;
        cyc = 0;
        while (ready_cnt < 2 && cyc < 100) begin
            step();
            cyc++;
        end
        check("midfill_beats", 64'(ready_cnt), 2);
        step();
        reset         = 1'b1;
        pend          = 0;
        bus.mem_ready = 1'b0;
        addr_q.delete();
        step();
        check_quiet("midfill_rst");
        check("midfill_rst_ishit", 64'(bus.ishit), 0);
        reset = 1'b0;
        step();
        bus.mem_ready = 1'b1;
        bus.mem_data  = {4{32'hBAD0_0BAD}};
        step();
        step();
        check_quiet("stray");
        check("stray_mem_addr", 64'(bus.mem_addr), 0);
        fetch(32'hC0, 1'b0, -1);
        fetch(32'hC4, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
